mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Issue/writeback controller for the RV32M multiply path. Sits directly upstream and downstream of the 34-bit radix-4 Booth multiplier stage.
- Accepts MUL/MULH/MULHSU/MULHU requests from the execute stage over a valid/ready handshake. Conditions operands to 34-bit signed form, sequences the multiplier through its reset/run cycle, and waits for its done pulse.
- Selects the low or high result word and returns it over a second valid/ready handshake with the destination-register tag.
- Includes a watchdog that converts a hung multiplier into an error response.

Parameters:
- XLEN, 32, architectural operand/result width.
- MW, 34, multiplier operand width (XLEN+2); multiplier product width is 2*MW.
- TIMEOUT, 24, maximum cycles spent in WAIT before an error response.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  controller can accept
- req_funct3  in  3  [1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 ignored
- req_rs1  in  XLEN  operand A (multiplicand)
- req_rs2  in  XLEN  operand B (multiplier)
- req_rd  in  5  destination tag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  XLEN  result word
- resp_rd  out  5  tag echoed from accepted request
- resp_err  out  1  result invalid (watchdog fired)
- mb_rst  out  1  reset to multiplier stage
- mb_multiplicand  out  MW  sign/zero-extended rs1
- mb_multiplier  out  MW  sign/zero-extended rs2
- mb_out  in  2*MW  multiplier product
- mb_done  in  1  multiplier completion pulse

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_err=0, mb_rst=1, operand registers=0, state=IDLE, watchdog=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register the extended operands, funct3[1:0] and rd, then go to WAIT.
- Operand extension:
  - rs1 is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU.
  - rs2 is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
  - Both are extended by 2 bits to MW.
- mb_rst is combinational: rst | (state!=WAIT). The multiplier is held in reset outside WAIT, so it starts fresh for every operation.
- mb_multiplicand and mb_multiplier are driven from registers and held stable for the whole of WAIT.
- WAIT:
  - req_ready=0; the watchdog increments each cycle.
  - When mb_done=1, capture the result into resp_data, clear resp_err, and go to RESP:
    - MUL: mb_out[31:0]
    - all others: mb_out[63:32]
  - When the watchdog reaches TIMEOUT with no done, set resp_data=0 and resp_err=1, then go to RESP.
  - mb_done has priority over the watchdog in the same cycle.
- RESP:
  - resp_valid=1; resp_data, resp_rd and resp_err are held stable until resp_valid&&resp_ready.
  - After the handshake, go to IDLE with resp_valid=0.
  - No new request is accepted in the handshake cycle; minimum spacing between accepts is one IDLE cycle.
- Latency: with a conforming multiplier (done 18 edges after mb_rst falls), resp_valid rises 19 cycles after the accept edge.
- mb_done sampled outside WAIT is ignored.
- rst mid-operation: immediate return to IDLE, resp_valid=0, mb_rst=1, any pending result discarded.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, an accepted request with rs1==0 or rs2==0 goes directly to RESP with resp_data=0 and resp_err=0.
  - The multiplier is never released from reset for that request.
  - resp_valid rises 1 cycle after accept.
- Undefined: all requests go through WAIT; zero operands take the full 19-cycle latency.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD -> resp_data=0xFFFFFFEB, resp_err=0, resp_valid exactly 19 cycles after accept.
- MULH, 0x80000000 x 0x80000000 -> 0x40000000; MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU, rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. Check mb_multiplicand=0x3FFFFFFFF and mb_multiplier=0x0FFFFFFFF.
- Backpressure: resp_ready=0 for 10 cycles, then 1 -> resp_data/resp_rd stable throughout, req_ready=0 until one cycle after the handshake; a second request issued back-to-back is accepted then.
- Stub multiplier that never asserts done -> resp_valid with resp_err=1 and resp_data=0 after TIMEOUT=24 WAIT cycles. Assert rst at WAIT cycle 5 on a separate run -> resp_valid never asserts and req_ready=1 the next cycle.
- With MUL_ZERO_BYPASS_EN: MULH 0 x 0x12345678 -> resp_data=0 one cycle after accept and mb_rst stays 1. Without the macro: same result at 19 cycles.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//
// Issue/writeback controller for the RV32M multiply path. It accepts
// MUL/MULH/MULHSU/MULHU requests, sign/zero-extends the operands to the
// multiplier's MW-bit signed form, releases the multiplier from reset for the
// duration of the operation, waits for its done pulse and returns the selected
// result word with the destination tag. A watchdog turns a hung multiplier
// into an error response.
//
// Optional feature (compile-time macro MUL_ZERO_BYPASS_EN):
//   when defined, a request with a zero operand skips the multiplier and
//   responds with 0 in the cycle after accept.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_funct3          [1:0] selects MUL/MULH/MULHSU/MULHU, bit 2 ignored
//   req_rs1/rs2         operands A (multiplicand) and B (multiplier)
//   req_rd              destination tag
//   resp_valid/ready    response handshake
//   resp_data/rd/err    result word, echoed tag, watchdog error flag
//   mb_rst              reset to the multiplier stage
//   mb_multiplicand     extended rs1
//   mb_multiplier       extended rs2
//   mb_out, mb_done     multiplier product and completion pulse
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int MW      = 34,
    parameter int TIMEOUT = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              mb_rst,
    output logic [MW-1:0]     mb_multiplicand,
    output logic [MW-1:0]     mb_multiplier,
    input  logic [2*MW-1:0]   mb_out,
    input  logic              mb_done
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [MW-1:0]       r_mcand, w_mcand_next;
    logic [MW-1:0]       r_mplier, w_mplier_next;
    logic [1:0]          r_funct, w_funct_next;
    logic [4:0]          r_rd, w_rd_next;
    logic [XLEN-1:0]     r_data, w_data_next;
    logic                r_err, w_err_next;
    logic [WDW-1:0]      r_wd, w_wd_next;

    // Operand conditioning: rs1 is unsigned only for MULHU, rs2 is unsigned
    // for MULHSU and MULHU (funct3[1] set).
    logic                w_a_signed;
    logic                w_b_signed;
    logic [MW-1:0]       w_ext_a;
    logic [MW-1:0]       w_ext_b;
    logic                w_bypass;
    logic [XLEN-1:0]     w_result;
    logic                w_unused_bits;

    assign w_a_signed = (req_funct3[1:0] != 2'b11);
    assign w_b_signed = ~req_funct3[1];
    assign w_ext_a    = {{(MW-XLEN){w_a_signed & req_rs1[XLEN-1]}}, req_rs1};
    assign w_ext_b    = {{(MW-XLEN){w_b_signed & req_rs2[XLEN-1]}}, req_rs2};

`ifdef MUL_ZERO_BYPASS_EN
    // A zero operand makes every product word zero, so the multiplier is skipped.
    assign w_bypass = (req_rs1 == '0) || (req_rs2 == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // MUL returns the low word; MULH/MULHSU/MULHU the high word of the product.
    assign w_result = (r_funct == 2'b00) ? mb_out[XLEN-1:0] : mb_out[2*XLEN-1:XLEN];

    // Product bits above 2*XLEN only carry sign extension and funct3[2] is
    // don't-care; both are deliberately left unused.
    assign w_unused_bits = ^{mb_out[2*MW-1:2*XLEN], req_funct3[2]};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_funct  <= 2'b00;
            r_rd     <= 5'd0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_funct  <= w_funct_next;
            r_rd     <= w_rd_next;
            r_data   <= w_data_next;
            r_err    <= w_err_next;
            r_wd     <= w_wd_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next  = r_state;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_funct_next  = r_funct;
        w_rd_next     = r_rd;
        w_data_next   = r_data;
        w_err_next    = r_err;
        w_wd_next     = r_wd;

        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_mcand_next  = w_ext_a;
                    w_mplier_next = w_ext_b;
                    w_funct_next  = req_funct3[1:0];
                    w_rd_next     = req_rd;
                    w_wd_next     = '0;
                    if (w_bypass) begin
                        w_data_next  = '0;
                        w_err_next   = 1'b0;
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A done pulse wins over a watchdog expiry in the same cycle.
                if (mb_done) begin
                    w_data_next  = w_result;
                    w_err_next   = 1'b0;
                    w_state_next = S_RESP;
                end else if (r_wd == WDW'(TIMEOUT - 1)) begin
                    w_data_next  = '0;
                    w_err_next   = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_wd_next = WDW'(r_wd + 1'b1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign req_ready       = (r_state == S_IDLE);
    assign resp_valid      = (r_state == S_RESP);
    assign resp_data       = r_data;
    assign resp_rd         = r_rd;
    assign resp_err        = r_err;
    // Holding the multiplier in reset outside WAIT gives it a fresh start per
    // operation and makes stray done pulses harmless.
    assign mb_rst          = rst | (r_state != S_WAIT);
    assign mb_multiplicand = r_mcand;
    assign mb_multiplier   = r_mplier;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_issue_ctrl
//
// Self-checking bench for mul_issue_ctrl. A behavioural multiplier stub
// produces the product 18 edges after mb_rst falls (or never, when hung).
// Expected results come from a 64-bit arithmetic model of the RV32M ops.
// -----------------------------------------------------------------------------
module tb_mul_issue_ctrl;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mb_rst;
    logic [33:0] mb_multiplicand;
    logic [33:0] mb_multiplier;
    logic [67:0] mb_out;
    logic        mb_done;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.XLEN(32), .MW(34), .TIMEOUT(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_funct3     (req_funct3),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_rd         (req_rd),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_rd        (resp_rd),
        .resp_err       (resp_err),
        .mb_rst         (mb_rst),
        .mb_multiplicand(mb_multiplicand),
        .mb_multiplier  (mb_multiplier),
        .mb_out         (mb_out),
        .mb_done        (mb_done)
    );

    // ---------------- multiplier stub ----------------
    bit          hang;
    logic [5:0]  mcnt;
    logic signed [67:0] sa, sb, sp;

    always @(posedge clk) begin
        if (mb_rst) mcnt <= 6'd0;
        else if (mcnt != 6'd63) mcnt <= mcnt + 6'd1;
    end

    // Done is sampled at the 18th edge after mb_rst falls.
    assign mb_done = !hang && !mb_rst && (mcnt == 6'd17);

    always_comb begin
        sa = {{34{mb_multiplicand[33]}}, mb_multiplicand};
        sb = {{34{mb_multiplier[33]}}, mb_multiplier};
        sp = sa * sb;
        // Garbage outside the done cycle exposes an early capture.
        mb_out = mb_done ? sp : 68'h5_A5A5_A5A5_A5A5_A5A5;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        xb = op[1] ? {32'd0, b} : {{32{b[31]}}, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [33:0] ext34(input logic [31:0] v, input bit sgn);
        return sgn ? {{2{v[31]}}, v} : {2'b00, v};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        return (BYPASS && (a == 32'd0 || b == 32'd0)) ? 1 : 19;
    endfunction

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one transaction. Must be entered just after a negedge; returns just
    // after a negedge one cycle past the response handshake.
    task automatic run_txn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int hold, input bit byp,
                           input logic [33:0] ea, input logic [33:0] eb,
                           output logic [31:0] d, output logic [4:0] ro,
                           output logic e, output int lat);
        bit ok;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("req_ready_busy", {63'd0, req_ready}, 64'd0);
                if (byp) begin
                    check("mb_rst_bypass", {63'd0, mb_rst}, 64'd1);
                end else begin
                    check("mb_rst_run", {63'd0, mb_rst}, 64'd0);
                    check("mb_multiplicand", {30'd0, mb_multiplicand}, {30'd0, ea});
                    check("mb_multiplier", {30'd0, mb_multiplier}, {30'd0, eb});
                end
            end
            if (resp_valid || lat >= 60) break;
        end
        d  = resp_data;
        ro = resp_rd;
        e  = resp_err;
        if (hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!resp_valid || resp_data !== d || resp_rd !== ro || resp_err !== e || req_ready)
                    ok = 1'b0;
            end
            check("resp_hold_stable", {63'd0, ok}, 64'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("resp_valid_after_hs", {63'd0, resp_valid}, 64'd0);
        check("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
        $display("txn f3=%0d rs1=%08h rs2=%08h rd=%0d -> data=%08h rd=%0d err=%0d lat=%0d",
                 f3, a, b, rd, d, ro, e, lat);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          hold;
        logic [33:0] ea;
        logic [33:0] eb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] d;
        logic [4:0]  ro;
        logic        e;
        int          lat;
        bit          byp;
        bit          never;

        vecs[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  0, 34'h0_0000_0007, 34'h3_FFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  0, 34'h3_8000_0000, 34'h3_8000_0000, 32'h4000_0000};
        vecs[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  0, 34'h0_FFFF_FFFF, 34'h0_FFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 10, 34'h3_FFFF_FFFF, 34'h0_FFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{3'b001, 32'h0000_0000, 32'h1234_5678, 5'd5,  0, 34'h0_0000_0000, 34'h0_1234_5678, 32'h0000_0000};
        vecs[5] = '{3'b101, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd17, 2, 34'h0_7FFF_FFFF, 34'h0_7FFF_FFFF, 32'h3FFF_FFFF};

        hang       = 1'b0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_rs1    = 32'd0;
        req_rs2    = 32'd0;
        req_rd     = 5'd0;
        resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data}, 64'd0);
        check("rst_resp_rd", {59'd0, resp_rd}, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_mb_rst", {63'd0, mb_rst}, 64'd1);
        check("rst_mb_ops", {30'd0, mb_multiplicand ^ mb_multiplier}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_mb_rst", {63'd0, mb_rst}, 64'd1);

        // Directed table; each entry starts right after the previous handshake
        for (int i = 0; i < 6; i++) begin
            byp = BYPASS && (vecs[i].a == 32'd0 || vecs[i].b == 32'd0);
            run_txn(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].hold, byp,
                    vecs[i].ea, vecs[i].eb, d, ro, e, lat);
            check("vec_data", {32'd0, d}, {32'd0, vecs[i].exp});
            check("vec_rd", {59'd0, ro}, {59'd0, vecs[i].rd});
            check("vec_err", {63'd0, e}, 64'd0);
            check("vec_latency", 64'(lat), 64'(exp_lat(vecs[i].a, vecs[i].b)));
        end

        // Watchdog: hung multiplier -> error after 24 WAIT cycles
        hang = 1'b1;
        run_txn(3'b000, 32'd3, 32'd5, 5'd9, 1, 1'b0, 34'd3, 34'd5, d, ro, e, lat);
        check("wd_err", {63'd0, e}, 64'd1);
        check("wd_data", {32'd0, d}, 64'd0);
        check("wd_rd", {59'd0, ro}, 64'd9);
        check("wd_latency", 64'(lat), 64'd25);

        // Reset in WAIT cycle 5 discards the operation
        req_valid  = 1'b1;
        req_funct3 = 3'b001;
        req_rs1    = 32'h1111_1111;
        req_rs2    = 32'h2222_2222;
        req_rd     = 5'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("midrst_mb_rst", {63'd0, mb_rst}, 64'd1);
        @(negedge clk);
        rst  = 1'b0;
        hang = 1'b0;
        never = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || !req_ready) never = 1'b0;
        end
        check("midrst_no_resp", {63'd0, never}, 64'd1);

        // Randomized transactions against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int          hold;
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            rd   = 5'($urandom_range(0, 31));
            hold = $urandom_range(0, 3);
            byp  = BYPASS && (a == 32'd0 || b == 32'd0);
            run_txn(f3, a, b, rd, hold, byp,
                    ext34(a, f3[1:0] != 2'b11), ext34(b, !f3[1]), d, ro, e, lat);
            check("rnd_data", {32'd0, d}, {32'd0, ref_mul(f3[1:0], a, b)});
            check("rnd_rd", {59'd0, ro}, {59'd0, rd});
            check("rnd_err", {63'd0, e}, 64'd0);
            check("rnd_latency", 64'(lat), 64'(exp_lat(a, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
